// File: rtl/ama_riscv_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with valid/ready request and response channels.
// Optional AMA_RISCV_DIV_EARLY_OUT_EN: trivial operations (x/0, signed overflow, |a|<|b|) skip the iteration phase.
module ama_riscv_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      op_sel,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] out_s
);

  localparam int              CW       = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] dvd_q, dvd_d;   // dividend, becomes the quotient as bits shift in
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_quo_q, sign_quo_d;
  logic            sign_rem_q, sign_rem_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic            resp_valid_q, resp_valid_d;

  // Accept-side operand conditioning.
  logic            is_signed, a_neg, b_neg, in_div0, in_ovf, early_out;
  logic [XLEN-1:0] mag_a, mag_b;

  assign is_signed = ~op_sel[0];
  assign a_neg     = is_signed & in_a[XLEN-1];
  assign b_neg     = is_signed & in_b[XLEN-1];
  assign mag_a     = a_neg ? (-in_a) : in_a;
  assign mag_b     = b_neg ? (-in_b) : in_b;
  assign in_div0   = (in_b == '0);
  assign in_ovf    = is_signed && (in_a == MIN_NEG) && (in_b == '1);

`ifdef AMA_RISCV_DIV_EARLY_OUT_EN
  assign early_out = in_div0 | in_ovf | (mag_a < mag_b);
`else
  assign early_out = 1'b0;
`endif

  // One restoring step: the borrow out of the widened subtract decides the quotient bit.
  logic [XLEN:0] rem_sh, diff;
  logic          take;

  assign rem_sh = {rem_q, dvd_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign take   = ~diff[XLEN];

  logic [XLEN-1:0] quo_fix, rem_fix, quo_res, rem_res;

  always_comb begin
    quo_fix = sign_quo_q ? (-dvd_q) : dvd_q;
    rem_fix = sign_rem_q ? (-rem_q) : rem_q;
    quo_res = quo_fix;
    rem_res = rem_fix;
    if (div0_q) begin
      quo_res = '1;
      rem_res = a_q;
    end else if (ovf_q) begin
      quo_res = MIN_NEG;
      rem_res = '0;
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
    state_d      = state_q;
    op_d         = op_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    rem_d        = rem_q;
    a_d          = a_q;
    out_d        = out_q;
    cnt_d        = cnt_q;
    sign_quo_d   = sign_quo_q;
    sign_rem_d   = sign_rem_q;
    div0_d       = div0_q;
    ovf_d        = ovf_q;
    resp_valid_d = resp_valid_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d       = op_sel;
          sign_quo_d = a_neg ^ b_neg;
          sign_rem_d = a_neg;
          div0_d     = in_div0;
          ovf_d      = in_ovf;
          a_d        = in_a;
          dvs_d      = mag_b;
          cnt_d      = CNT_INIT;
          if (early_out) begin
            dvd_d   = '0;
            rem_d   = mag_a;
            state_d = DONE;
          end else begin
            dvd_d   = mag_a;
            rem_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[XLEN-2:0], take};
        rem_d = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DONE: begin
        // First DONE cycle registers the sign-fixed result; the response is then held until taken.
        if (!resp_valid_q) begin
          out_d        = op_q[1] ? rem_res : quo_res;
          resp_valid_d = 1'b1;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments for all state; datapath registers are reset too so out_s starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      a_q          <= '0;
      out_q        <= '0;
      cnt_q        <= '0;
      sign_quo_q   <= 1'b0;
      sign_rem_q   <= 1'b0;
      div0_q       <= 1'b0;
      ovf_q        <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      rem_q        <= rem_d;
      a_q          <= a_d;
      out_q        <= out_d;
      cnt_q        <= cnt_d;
      sign_quo_q   <= sign_quo_d;
      sign_rem_q   <= sign_rem_d;
      div0_q       <= div0_d;
      ovf_q        <= ovf_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign out_s      = out_q;

endmodule
